ram_dp_clr: RTL and testbench
=============================

Name: ram_dp_clr

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, single clock.
- Successor to the single-port registered-address RAM used for MRELBP line and feature buffering.
- Adds independent read/write addresses, read enable with valid flag, and an optional extra output register.
- Adds a selectable read-during-write policy and a built-in clear engine that zero-fills the array after reset or on request.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output pipeline register, giving latency 2.
- RDW_MODE, 0, same-address read during write: 0 returns old data, 1 returns new data (write-first bypass).
- CLEAR_ON_RESET, 1, 1 starts a full clear automatically when reset is released.

Ports:
- i_clk  in  1  global clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wr_en  in  1  write enable.
- i_wr_addr  in  ADDR_WIDTH  write address.
- i_wr_data  in  DATA_WIDTH  write data.
- i_rd_en  in  1  read request.
- i_rd_addr  in  ADDR_WIDTH  read address.
- i_clr  in  1  single-cycle pulse; requests a full clear.
- o_rd_data  out  DATA_WIDTH  read data.
- o_rd_valid  out  1  o_rd_data is valid this cycle.
- o_busy  out  1  clear in progress; user ports are ignored while high.

Behaviour:
- Reset values:
  - o_rd_data = 0, o_rd_valid = 0, all valid pipeline stages = 0.
  - Clear counter = 0.
  - FSM = CLEAR with o_busy = 1 if CLEAR_ON_RESET = 1; otherwise FSM = IDLE with o_busy = 0.
  - Array contents are not reset by i_rst; only the clear engine zeroes them.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when i_clr = 1.
  - In CLEAR, write 0 to address clr_cnt each cycle and increment clr_cnt.
  - CLEAR -> IDLE in the cycle that writes address DEPTH-1; clr_cnt wraps to 0.
  - o_busy is high for exactly DEPTH cycles and is 0 in the cycle after the last clear write.
- During CLEAR:
  - i_wr_en, i_rd_en and i_clr are ignored.
  - No user write reaches the array.
  - o_rd_valid stays 0 once reads already in flight have drained.
- i_rst asserted mid-clear aborts the clear. On release, the clear restarts from address 0 if CLEAR_ON_RESET = 1; otherwise the array is left partially cleared.
- Write (IDLE): when i_wr_en = 1, mem[i_wr_addr] <= i_wr_data on the rising edge.
- Read (IDLE): when i_rd_en = 1, the word at i_rd_addr is captured on the edge.
  - OUT_REG = 0: o_rd_data updates at edge N+1 with o_rd_valid = 1 for that one cycle.
  - OUT_REG = 1: the same happens one cycle later.
- o_rd_data holds its last value when no read completes; o_rd_valid = 0 in those cycles.
- Back-to-back reads: one per cycle, fully pipelined, no bubbles.
- Same-address read and write in the same cycle:
  - RDW_MODE = 0 returns the pre-write word.
  - RDW_MODE = 1 returns i_wr_data through a registered bypass.
- Different addresses in the same cycle are fully independent.
- Addresses cover the full 2**ADDR_WIDTH range, so no out-of-range case exists.

Decomposition:
- Package ram_pkg:
  - typedef of the FSM state enum (ST_IDLE, ST_CLEAR).
  - constants RDW_OLD = 0 and RDW_NEW = 1.
- One sub-module, ram_sdp_core: the bare simple dual-port array with synchronous read and the RDW_MODE bypass, written so it infers block RAM.
- The top level holds the clear FSM, the write/read port muxing (clear engine vs. user), the OUT_REG stage and the valid pipeline.

Test Plan:
- Reset release with CLEAR_ON_RESET = 1 -> o_busy = 1 for exactly 64 cycles. Then read all 64 addresses -> every o_rd_data = 0x00, each with o_rd_valid = 1 one cycle after its i_rd_en.
- Write 0xA5 to address 3, then read address 3 (OUT_REG = 0) -> o_rd_data = 0xA5, valid 1 cycle later. Repeat with OUT_REG = 1 -> valid 2 cycles later.
- mem[7] = 0x11, then same cycle write 0x22 to address 7 and read address 7 -> RDW_MODE = 0 gives 0x11; RDW_MODE = 1 gives 0x22. A following read of address 7 gives 0x22 in both modes.
- Streaming reads of addresses 0..9 on consecutive cycles after writing data = addr + 1 -> o_rd_valid high for 10 consecutive cycles with outputs 0x01..0x0A in order.
- Pulse i_clr in IDLE with a write to address 5 asserted during CLEAR -> the write is ignored, o_busy lasts 64 cycles, and address 5 reads 0x00 afterwards.
- Assert i_rst at clear cycle 20 and release -> o_busy is high again for a full 64 cycles, restarting from address 0; o_rd_data and o_rd_valid are 0 during reset.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the clearable simple dual-port RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

endpackage

// File: rtl/ram_sdp_core.sv
// Bare simple dual-port array: synchronous write, registered read, optional
// write-first bypass for same-address read during write.
module ram_sdp_core
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  // Array storage is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first capture: a same-edge write is not yet visible here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_q <= '0;
    else if (re) ram_q <= mem[raddr];
  end

  generate
    if (RDW_MODE == RDW_NEW) begin : g_bypass
      logic                  byp_hit_q;
      logic [DATA_WIDTH-1:0] byp_data_q;

      // Bypass state only changes with a read so the output holds between reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          byp_hit_q  <= 1'b0;
          byp_data_q <= '0;
        end else if (re) begin
          byp_hit_q  <= we && (waddr == raddr);
          byp_data_q <= wdata;
        end
      end

      assign rd_data_c = byp_hit_q ? byp_data_q : ram_q;
    end else begin : g_no_bypass
      assign rd_data_c = ram_q;
    end
  endgenerate

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with clear engine, read-valid pipeline and optional
// output register.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_clr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;

  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_waddr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic                  mem_re_c;
  logic [DATA_WIDTH-1:0] core_data_c;
  logic                  valid_q1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Clear FSM: one zero write per cycle, leaves CLEAR on the last address.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_IDLE: begin
        if (i_clr) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
        if (clr_cnt == LAST_ADDR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (state == ST_CLEAR);

  // Clear engine owns the write port; user ports are gated off while busy.
  always_comb begin
    mem_we_c    = i_wr_en;
    mem_waddr_c = i_wr_addr;
    mem_wdata_c = i_wr_data;
    mem_re_c    = i_rd_en && (state == ST_IDLE);
    if (state == ST_CLEAR) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = clr_cnt;
      mem_wdata_c = '0;
    end
  end

  ram_sdp_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RDW_MODE  (RDW_MODE)
  ) u_core (
    .clk      (i_clk),
    .rst      (i_rst),
    .we       (mem_we_c),
    .waddr    (mem_waddr_c),
    .wdata    (mem_wdata_c),
    .re       (mem_re_c),
    .raddr    (i_rd_addr),
    .rd_data_c(core_data_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) valid_q1 <= 1'b0;
    else valid_q1 <= mem_re_c;
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  valid_q2;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          rd_data_q <= '0;
          valid_q2  <= 1'b0;
        end else begin
          valid_q2 <= valid_q1;
          if (valid_q1) rd_data_q <= core_data_c;
        end
      end

      assign o_rd_data  = rd_data_q;
      assign o_rd_valid = valid_q2;
    end else begin : g_direct
      assign o_rd_data  = core_data_c;
      assign o_rd_valid = valid_q1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: latency-1/read-old, latency-2/write-first,
// and no-auto-clear instances share one stimulus stream.
module tb_ram_dp_clr;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       clr;

  logic [7:0] rd_data0, rd_data1, rd_data2;
  logic       valid0, valid1, valid2;
  logic       busy0, busy1, busy2;

  int n_tests = 0;
  int n_fail  = 0;

  ram_dp_clr #(.OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_clr(clr),
    .o_rd_data(rd_data0), .o_rd_valid(valid0), .o_busy(busy0)
  );

  ram_dp_clr #(.OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_clr(clr),
    .o_rd_data(rd_data1), .o_rd_valid(valid1), .o_busy(busy1)
  );

  ram_dp_clr #(.OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_clr(clr),
    .o_rd_data(rd_data2), .o_rd_valid(valid2), .o_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic count_busy(input int which, output int cycles);
    cycles = 0;
    while (((which == 0) ? busy0 : busy1) && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    int cyc0, cyc1;
    int seen_valid;
    logic [7:0] exp1;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr = 1'b0;
    tick(); tick();

    chk("rst_data0", 32'(rd_data0), 32'h0);
    chk("rst_valid0", 32'(valid0), 32'h0);
    chk("rst_data1", 32'(rd_data1), 32'h0);
    chk("rst_valid1", 32'(valid1), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h1);
    chk("rst_busy2", 32'(busy2), 32'h0);

    // Auto clear after reset release
    rst = 1'b0;
    fork
      count_busy(0, cyc0);
    join
    chk("auto_clr_busy0_cycles", 32'(cyc0), 32'd64);
    chk("auto_clr_busy1", 32'(busy1), 32'h0);
    chk("auto_clr_busy2", 32'(busy2), 32'h0);

    // Sweep all addresses: zero everywhere
    for (int a = 0; a < 64; a++) begin
      rd_en = 1'b1; rd_addr = 6'(a);
      tick();
      rd_en = 1'b0;
      chk($sformatf("sweep_v0_%0d", a), 32'(valid0), 32'h1);
      chk($sformatf("sweep_d0_%0d", a), 32'(rd_data0), 32'h0);
      chk($sformatf("sweep_v1early_%0d", a), 32'(valid1), 32'h0);
      tick();
      chk($sformatf("sweep_v1_%0d", a), 32'(valid1), 32'h1);
      chk($sformatf("sweep_d1_%0d", a), 32'(rd_data1), 32'h0);
    end

    // Write 0xA5 to 3, read back with both latencies
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 6'd3;
    tick();
    rd_en = 1'b0;
    chk("a5_v0", 32'(valid0), 32'h1);
    chk("a5_d0", 32'(rd_data0), 32'hA5);
    chk("a5_v1_lat", 32'(valid1), 32'h0);
    tick();
    chk("a5_v0_drop", 32'(valid0), 32'h0);
    chk("a5_d0_hold", 32'(rd_data0), 32'hA5);
    chk("a5_v1", 32'(valid1), 32'h1);
    chk("a5_d1", 32'(rd_data1), 32'hA5);
    tick();
    chk("a5_v1_drop", 32'(valid1), 32'h0);

    // Read during write on address 7
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'h11;
    tick();
    wr_data = 8'h22; rd_en = 1'b1; rd_addr = 6'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_d0_old", 32'(rd_data0), 32'h11);
    chk("rdw_v0", 32'(valid0), 32'h1);
    tick();
    chk("rdw_d1_new", 32'(rd_data1), 32'h22);
    chk("rdw_v1", 32'(valid1), 32'h1);
    rd_en = 1'b1; rd_addr = 6'd7;
    tick();
    rd_en = 1'b0;
    chk("rdw_after_d0", 32'(rd_data0), 32'h22);
    tick();
    chk("rdw_after_d1", 32'(rd_data1), 32'h22);
    chk("rdw_after_v1", 32'(valid1), 32'h1);
    tick();

    // Different-address write and read in one cycle stay independent
    wr_en = 1'b1; wr_addr = 6'd8; wr_data = 8'h77; rd_en = 1'b1; rd_addr = 6'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("indep_d0", 32'(rd_data0), 32'hA5);
    tick();
    chk("indep_d1", 32'(rd_data1), 32'hA5);

    // Streaming reads 0..9 with data = addr + 1
    for (int a = 0; a < 10; a++) begin
      wr_en = 1'b1; wr_addr = 6'(a); wr_data = 8'(a + 1);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rd_en = (i < 10); rd_addr = 6'(i);
      tick();
      chk($sformatf("stream_v0_%0d", i), 32'(valid0), 32'(i < 10));
      chk($sformatf("stream_d0_%0d", i), 32'(rd_data0), (i < 10) ? 32'(i + 1) : 32'd10);
      exp1 = (i == 0) ? 8'hA5 : ((i <= 10) ? 8'(i) : 8'd10);
      chk($sformatf("stream_v1_%0d", i), 32'(valid1), 32'(i >= 1 && i <= 10));
      chk($sformatf("stream_d1_%0d", i), 32'(rd_data1), 32'(exp1));
    end
    rd_en = 1'b0;

    // Requested clear with user write/read held during CLEAR
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy2", 32'(busy2), 32'h1);
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hFF; rd_en = 1'b1; rd_addr = 6'd5;
    cyc0 = 0; seen_valid = 0;
    while (busy0 && cyc0 < 200) begin
      if (valid0 || valid1) seen_valid++;
      cyc0++;
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("clr_busy0_cycles", 32'(cyc0), 32'd64);
    chk("clr_no_valid", 32'(seen_valid), 32'h0);
    chk("clr_busy1_done", 32'(busy1), 32'h0);
    chk("clr_valid0_after", 32'(valid0), 32'h0);
    foreach (exp1[k]) begin end
    for (int j = 0; j < 3; j++) begin
      rd_en = 1'b1; rd_addr = (j == 0) ? 6'd5 : ((j == 1) ? 6'd3 : 6'd7);
      tick();
      rd_en = 1'b0;
      chk($sformatf("clr_rd0_%0d", rd_addr), 32'(rd_data0), 32'h0);
      chk($sformatf("clr_rv0_%0d", rd_addr), 32'(valid0), 32'h1);
      tick();
      chk($sformatf("clr_rd1_%0d", rd_addr), 32'(rd_data1), 32'h0);
    end

    // Reset in the middle of a clear restarts it from address 0
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 6'd9;
    tick();
    rd_en = 1'b0;
    tick();
    chk("pre_rst_d0", 32'(rd_data0), 32'h3C);
    chk("pre_rst_d1", 32'(rd_data1), 32'h3C);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    chk("mid_busy0", 32'(busy0), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_d0", 32'(rd_data0), 32'h0);
    chk("mid_rst_v0", 32'(valid0), 32'h0);
    chk("mid_rst_d1", 32'(rd_data1), 32'h0);
    chk("mid_rst_v1", 32'(valid1), 32'h0);
    chk("mid_rst_busy2", 32'(busy2), 32'h0);
    tick(); tick();
    rst = 1'b0;
    count_busy(1, cyc1);
    chk("restart_busy1_cycles", 32'(cyc1), 32'd64);
    chk("restart_busy0", 32'(busy0), 32'h0);
    rd_en = 1'b1; rd_addr = 6'd9;
    tick();
    rd_en = 1'b0;
    chk("restart_rd0", 32'(rd_data0), 32'h0);
    tick();
    chk("restart_rd1", 32'(rd_data1), 32'h0);
    chk("restart_rv1", 32'(valid1), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
